rs_aged: RTL and testbench
==========================

RS_AGED -- requirements
Module: rs_aged

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, ROB tag width; tag 0 means "no dependency/invalid".
REQ-003 SHALL have parameter DATA_W, default 32, operand/imm/pc width.
REQ-004 SHALL have parameter OP_W, default 6, internal opcode width.
REQ-005 SHALL have parameter CDB_N, default 3, number of broadcast channels.
REQ-006 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: rdy  in  1  global enable; low freezes all state.
REQ-008 SHALL have ports: in_valid  in  1, in_rob_tag  in  TAG_W, in_op  in  OP_W, in_value1/in_value2/in_imm/in_pc  in  DATA_W each, in_tag1/in_tag2  in  TAG_W each: insert request.
REQ-009 SHALL have port: out_in_ready  out  1  high when an insert is accepted this cycle.
REQ-010 SHALL have ports: in_cdb_valid  in  CDB_N; in_cdb_tag  in  CDB_N*TAG_W; in_cdb_value  in  CDB_N*DATA_W; channel k at slice k.
REQ-011 SHALL have ports: out_alu_valid  out  1; out_alu_op  out  OP_W; out_alu_value1/out_alu_value2/out_alu_imm/out_alu_pc  out  DATA_W; out_alu_rob_tag  out  TAG_W; in_alu_ready  in  1.
REQ-012 SHALL have ports: in_flush  in  1  misbranch flush; out_count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-013 out_in_ready SHALL be combinational: out_count < DEPTH; no same-cycle-issue credit.
REQ-014 Insert SHALL occur when rdy & in_valid & out_in_ready & in_rob_tag!=0 & !in_flush; into lowest-index free entry.
REQ-015 Insert SHALL bypass all CDB channels: a source tag matching any valid nonzero CDB tag that cycle is stored with tag 0 and the CDB value.
REQ-016 Each busy entry SHALL capture, per source, the value of any valid CDB channel with nonzero tag equal to its source tag, clearing that tag to 0; equal tags on several channels: lowest channel index wins.
REQ-017 Entry ready SHALL be busy & tag1==0 & tag2==0, evaluated on registered state (wakeup-to-issue latency 1 cycle).
REQ-018 Each entry SHALL hold age rank = number of older busy entries; insert gets rank = out_count minus 1 if an issue occurs same cycle, else out_count.
REQ-019 On issue of rank-k entry, all entries with rank > k SHALL decrement by 1; ranks of busy entries always form 0..out_count-1.
REQ-020 Issue selection SHALL pick the ready entry with the smallest rank (oldest first).
REQ-021 Issue SHALL occur when a ready entry exists and (!out_alu_valid | in_alu_ready); selected entry loads output registers, is freed, out_alu_valid <= 1.
REQ-022 When out_alu_valid & in_alu_ready and no entry issues, out_alu_valid SHALL clear next cycle; when out_alu_valid & !in_alu_ready, all out_alu_* SHALL hold.
REQ-023 out_count SHALL update +1 insert, -1 issue, unchanged if both or neither.
REQ-024 in_flush (rdy high) SHALL clear all busy bits, out_alu_valid, out_count next cycle; insert and issue that cycle are discarded; flush overrides all.
REQ-025 rdy low SHALL hold every register including output stage; handshake and CDB ignored.

Reset
REQ-026 rst low SHALL immediately clear all busy bits, ranks, out_count to 0 and out_alu_valid to 0; out_alu_op and other outputs SHALL reset to 0.
REQ-027 Reset asserted mid-operation SHALL discard all entries and the pending output without completion.
REQ-028 First insert SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-029 Insert tags (5,0,0),(6,0,0),(7,0,0), in_alu_ready=1 -> issues rob 5,6,7 on consecutive cycles, out_count peaks 1.
REQ-030 Insert rob 3 waiting tag1=9, then rob 4 ready; then CDB ch2 tag 9 value 0x55 -> rob 4 issues first; rob 3 issues one cycle after broadcast with value1=0x55.
REQ-031 Insert rob 8 tag2=2 while CDB ch0 broadcasts tag 2 value 0xAB same cycle -> entry ready next cycle, issues with value2=0xAB.
REQ-032 Fill 16 entries with unresolved tags -> out_in_ready=0, 17th insert ignored, out_count=16; resolve all with one CDB tag -> issue in insertion order, one per cycle.
REQ-033 Hold in_alu_ready=0 for 3 cycles with out_alu_valid=1 -> outputs stable, no further entry freed; release -> next oldest follows.
REQ-034 in_flush with 5 busy entries and concurrent insert -> next cycle out_count=0, out_alu_valid=0, no issue.

Source files
------------

// File: rtl/rs_aged.sv
// Age-ordered reservation station: CDB wakeup, oldest-ready-first issue into a
// single registered ALU output stage with valid/ready handshake.
module rs_aged #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned CDB_N  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      in_valid,
  input  logic [TAG_W-1:0]          in_rob_tag,
  input  logic [OP_W-1:0]           in_op,
  input  logic [DATA_W-1:0]         in_value1,
  input  logic [DATA_W-1:0]         in_value2,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [TAG_W-1:0]          in_tag1,
  input  logic [TAG_W-1:0]          in_tag2,
  output logic                      out_in_ready,
  input  logic [CDB_N-1:0]          in_cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]    in_cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]   in_cdb_value,
  output logic                      out_alu_valid,
  output logic [OP_W-1:0]           out_alu_op,
  output logic [DATA_W-1:0]         out_alu_value1,
  output logic [DATA_W-1:0]         out_alu_value2,
  output logic [DATA_W-1:0]         out_alu_imm,
  output logic [DATA_W-1:0]         out_alu_pc,
  output logic [TAG_W-1:0]          out_alu_rob_tag,
  input  logic                      in_alu_ready,
  input  logic                      in_flush,
  output logic [$clog2(DEPTH):0]    out_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  rob_tag;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag1;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] value1;
    logic [DATA_W-1:0] value2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] value;
  } cdb_hit_t;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [IDX_W-1:0] rank_q [DEPTH];
  logic [IDX_W-1:0] rank_d [DEPTH];
  entry_t           ent_q  [DEPTH];
  entry_t           ent_d  [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] ready_c;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_rank;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] ins_rank;
  entry_t           ins_ent;
  logic             do_ins;
  logic             do_iss;

  // Lowest-index valid channel carrying a nonzero tag equal to tag wins.
  function automatic cdb_hit_t cdb_lookup(input logic [TAG_W-1:0] tag);
    cdb_hit_t r;
    r = '0;
    for (int k = int'(CDB_N) - 1; k >= 0; k--) begin
      if (in_cdb_valid[k] && (tag != '0) && (in_cdb_tag[k*TAG_W +: TAG_W] == tag)) begin
        r.hit   = 1'b1;
        r.value = in_cdb_value[k*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  assign out_in_ready = (count_q < CNT_W'(DEPTH));
  assign out_count    = count_q;

  // Oldest ready entry and lowest free slot, from registered state only.
  always_comb begin
    ready_c    = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_rank   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ready_c[i] = busy_q[i] && (ent_q[i].tag1 == '0) && (ent_q[i].tag2 == '0);
      if (ready_c[i] && (!sel_found || (rank_q[i] < sel_rank))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = rank_q[i];
      end
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign do_iss = rdy && !in_flush && sel_found && (!out_alu_valid || in_alu_ready);
  assign do_ins = rdy && in_valid && out_in_ready && free_found &&
                  (in_rob_tag != '0) && !in_flush;
  assign ins_rank = do_iss ? IDX_W'(count_q - CNT_W'(1)) : IDX_W'(count_q);

  // Incoming entry with same-cycle CDB bypass on both sources.
  always_comb begin
    cdb_hit_t m1, m2;
    m1 = cdb_lookup(in_tag1);
    m2 = cdb_lookup(in_tag2);
    ins_ent.rob_tag = in_rob_tag;
    ins_ent.op      = in_op;
    ins_ent.imm     = in_imm;
    ins_ent.pc      = in_pc;
    ins_ent.tag1    = m1.hit ? '0 : in_tag1;
    ins_ent.value1  = m1.hit ? m1.value : in_value1;
    ins_ent.tag2    = m2.hit ? '0 : in_tag2;
    ins_ent.value2  = m2.hit ? m2.value : in_value2;
  end

  // Next entry state: wakeup, issue compaction of ranks, insert, flush.
  always_comb begin
    cdb_hit_t h1, h2;
    busy_d  = busy_q;
    rank_d  = rank_q;
    ent_d   = ent_q;
    count_d = count_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      h1 = cdb_lookup(ent_q[i].tag1);
      h2 = cdb_lookup(ent_q[i].tag2);
      if (busy_q[i] && h1.hit) begin
        ent_d[i].tag1   = '0;
        ent_d[i].value1 = h1.value;
      end
      if (busy_q[i] && h2.hit) begin
        ent_d[i].tag2   = '0;
        ent_d[i].value2 = h2.value;
      end
      if (do_iss && busy_q[i] && (rank_q[i] > sel_rank)) begin
        rank_d[i] = rank_q[i] - IDX_W'(1);
      end
    end
    if (do_iss) begin
      busy_d[sel_idx] = 1'b0;
    end
    if (do_ins) begin
      busy_d[free_idx] = 1'b1;
      rank_d[free_idx] = ins_rank;
      ent_d[free_idx]  = ins_ent;
    end
    case ({do_ins, do_iss})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (in_flush) begin
      busy_d  = '0;
      count_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rank_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rank_q[i] <= '0;
        ent_q[i]  <= '0;
      end
    end else if (rdy) begin
      busy_q  <= busy_d;
      count_q <= count_d;
      rank_q  <= rank_d;
      ent_q   <= ent_d;
    end
  end

  // Output stage: load on issue, drop on consumed handshake, hold on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_alu_valid   <= 1'b0;
      out_alu_op      <= '0;
      out_alu_value1  <= '0;
      out_alu_value2  <= '0;
      out_alu_imm     <= '0;
      out_alu_pc      <= '0;
      out_alu_rob_tag <= '0;
    end else if (rdy) begin
      if (in_flush) begin
        out_alu_valid <= 1'b0;
      end else if (do_iss) begin
        out_alu_valid   <= 1'b1;
        out_alu_op      <= ent_q[sel_idx].op;
        out_alu_value1  <= ent_q[sel_idx].value1;
        out_alu_value2  <= ent_q[sel_idx].value2;
        out_alu_imm     <= ent_q[sel_idx].imm;
        out_alu_pc      <= ent_q[sel_idx].pc;
        out_alu_rob_tag <= ent_q[sel_idx].rob_tag;
      end else if (in_alu_ready) begin
        out_alu_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_aged.sv
// Directed bench for rs_aged: in-order issue, CDB wakeup/bypass, full stall,
// output backpressure, flush, rdy freeze and asynchronous reset.
module tb_rs_aged;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        in_valid;
  logic [3:0]  in_rob_tag;
  logic [5:0]  in_op;
  logic [31:0] in_value1, in_value2, in_imm, in_pc;
  logic [3:0]  in_tag1, in_tag2;
  logic        out_in_ready;
  logic [2:0]  in_cdb_valid;
  logic [11:0] in_cdb_tag;
  logic [95:0] in_cdb_value;
  logic        out_alu_valid;
  logic [5:0]  out_alu_op;
  logic [31:0] out_alu_value1, out_alu_value2, out_alu_imm, out_alu_pc;
  logic [3:0]  out_alu_rob_tag;
  logic        in_alu_ready;
  logic        in_flush;
  logic [4:0]  out_count;

  int tests = 0;
  int fails = 0;

  rs_aged dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_valid(in_valid), .in_rob_tag(in_rob_tag), .in_op(in_op),
    .in_value1(in_value1), .in_value2(in_value2), .in_imm(in_imm), .in_pc(in_pc),
    .in_tag1(in_tag1), .in_tag2(in_tag2), .out_in_ready(out_in_ready),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .out_alu_valid(out_alu_valid), .out_alu_op(out_alu_op),
    .out_alu_value1(out_alu_value1), .out_alu_value2(out_alu_value2),
    .out_alu_imm(out_alu_imm), .out_alu_pc(out_alu_pc),
    .out_alu_rob_tag(out_alu_rob_tag), .in_alu_ready(in_alu_ready),
    .in_flush(in_flush), .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, retire single-cycle pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_cdb_valid = '0;
    in_flush     = 1'b0;
  endtask

  task automatic ins(input logic [3:0] rob, input logic [3:0] t1, input logic [3:0] t2,
                     input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm);
    in_valid   = 1'b1;
    in_rob_tag = rob;
    in_op      = {2'b10, rob};
    in_tag1    = t1;
    in_tag2    = t2;
    in_value1  = v1;
    in_value2  = v2;
    in_imm     = imm;
    in_pc      = 32'h1000 + imm;
  endtask

  task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] val);
    in_cdb_valid[ch]          = 1'b1;
    in_cdb_tag[ch*4 +: 4]     = tag;
    in_cdb_value[ch*32 +: 32] = val;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; in_valid = 1'b0; in_rob_tag = '0; in_op = '0;
    in_value1 = '0; in_value2 = '0; in_imm = '0; in_pc = '0; in_tag1 = '0; in_tag2 = '0;
    in_cdb_valid = '0; in_cdb_tag = '0; in_cdb_value = '0; in_alu_ready = 1'b1; in_flush = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_valid", 32'(out_alu_valid), 32'd0);
    chk("rst_op", 32'(out_alu_op), 32'd0);
    chk("rst_in_ready", 32'(out_in_ready), 32'd1);
    rst = 1'b1;

    // Back-to-back ready inserts issue one per cycle, count peaks at 1
    ins(5, 0, 0, 32'h50, 32'h51, 32'h52); tick;
    chk("s1_first_insert_count", 32'(out_count), 32'd1);
    chk("s1_no_issue_yet", 32'(out_alu_valid), 32'd0);
    ins(6, 0, 0, 32'h60, 32'h61, 32'h62); tick;
    chk("s1_rob5_valid", 32'(out_alu_valid), 32'd1);
    chk("s1_rob5_tag", 32'(out_alu_rob_tag), 32'd5);
    chk("s1_rob5_v1", out_alu_value1, 32'h50);
    chk("s1_rob5_op", 32'(out_alu_op), 32'h25);
    chk("s1_count_a", 32'(out_count), 32'd1);
    ins(7, 0, 0, 32'h70, 32'h71, 32'h72); tick;
    chk("s1_rob6_tag", 32'(out_alu_rob_tag), 32'd6);
    chk("s1_count_b", 32'(out_count), 32'd1);
    tick;
    chk("s1_rob7_tag", 32'(out_alu_rob_tag), 32'd7);
    chk("s1_rob7_imm", out_alu_imm, 32'h72);
    chk("s1_rob7_pc", out_alu_pc, 32'h1072);
    chk("s1_count_c", 32'(out_count), 32'd0);
    tick;
    chk("s1_drain_valid", 32'(out_alu_valid), 32'd0);

    // Waiting entry woken by CDB ch2; younger ready entry goes first
    ins(3, 9, 0, 32'h0, 32'h22, 32'h33); tick;
    chk("s2_count_a", 32'(out_count), 32'd1);
    ins(4, 0, 0, 32'h44, 32'h45, 32'h46); tick;
    chk("s2_count_b", 32'(out_count), 32'd2);
    chk("s2_waiting_no_issue", 32'(out_alu_valid), 32'd0);
    cdb(2, 9, 32'h55); tick;
    chk("s2_rob4_tag", 32'(out_alu_rob_tag), 32'd4);
    chk("s2_rob4_v1", out_alu_value1, 32'h44);
    chk("s2_count_c", 32'(out_count), 32'd1);
    tick;
    chk("s2_rob3_tag", 32'(out_alu_rob_tag), 32'd3);
    chk("s2_rob3_v1", out_alu_value1, 32'h55);
    chk("s2_rob3_v2", out_alu_value2, 32'h22);
    chk("s2_count_d", 32'(out_count), 32'd0);
    tick;
    chk("s2_drain_valid", 32'(out_alu_valid), 32'd0);

    // Insert-time bypass; ch0 beats ch1 on the same tag
    ins(8, 0, 2, 32'h80, 32'h11, 32'h88);
    cdb(0, 2, 32'hAB);
    cdb(1, 2, 32'hCD);
    tick;
    chk("s3_count_a", 32'(out_count), 32'd1);
    chk("s3_no_issue_yet", 32'(out_alu_valid), 32'd0);
    tick;
    chk("s3_rob8_tag", 32'(out_alu_rob_tag), 32'd8);
    chk("s3_rob8_v2", out_alu_value2, 32'hAB);
    chk("s3_rob8_v1", out_alu_value1, 32'h80);
    chk("s3_count_b", 32'(out_count), 32'd0);
    tick;

    // Fill all 16 slots, 17th rejected, resolve with one broadcast
    for (int i = 0; i < 16; i++) begin
      ins(4'((i % 15) + 1), 10, 0, 32'h0, 32'h0, 32'(i));
      tick;
    end
    chk("s4_full_count", 32'(out_count), 32'd16);
    chk("s4_full_in_ready", 32'(out_in_ready), 32'd0);
    chk("s4_full_no_issue", 32'(out_alu_valid), 32'd0);
    ins(15, 0, 0, 32'h0, 32'h0, 32'hFF); tick;
    chk("s4_17th_ignored", 32'(out_count), 32'd16);
    chk("s4_17th_no_issue", 32'(out_alu_valid), 32'd0);
    cdb(1, 10, 32'h77); tick;
    chk("s4_wake_latency", 32'(out_alu_valid), 32'd0);
    tick;
    chk("s4_first_imm", out_alu_imm, 32'd0);
    chk("s4_first_v1", out_alu_value1, 32'h77);
    chk("s4_first_count", 32'(out_count), 32'd15);
    chk("s4_in_ready_back", 32'(out_in_ready), 32'd1);

    // Backpressure: output and occupancy hold for three cycles
    in_alu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("s5_hold_valid", 32'(out_alu_valid), 32'd1);
      chk("s5_hold_imm", out_alu_imm, 32'd0);
      chk("s5_hold_count", 32'(out_count), 32'd15);
    end
    in_alu_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick;
      chk("s5_order_imm", out_alu_imm, 32'(i));
      chk("s5_order_count", 32'(out_count), 32'(15 - i));
    end
    tick;
    chk("s5_drain_valid", 32'(out_alu_valid), 32'd0);

    // Flush with 5 busy entries, a pending output and a concurrent insert
    in_alu_ready = 1'b0;
    ins(1, 0, 0, 32'h10, 32'h0, 32'h100); tick;
    ins(2, 11, 0, 32'h0, 32'h0, 32'h200); tick;
    chk("s6_out_rob1", 32'(out_alu_rob_tag), 32'd1);
    chk("s6_count_a", 32'(out_count), 32'd1);
    ins(3, 11, 0, 32'h0, 32'h0, 32'h300); tick;
    ins(4, 11, 0, 32'h0, 32'h0, 32'h400); tick;
    ins(5, 11, 0, 32'h0, 32'h0, 32'h500); tick;
    ins(6, 0, 0, 32'h0, 32'h0, 32'h600); tick;
    chk("s6_count_b", 32'(out_count), 32'd5);
    chk("s6_held_rob1", 32'(out_alu_rob_tag), 32'd1);
    in_alu_ready = 1'b1;
    in_flush = 1'b1;
    ins(7, 0, 0, 32'h0, 32'h0, 32'h700); tick;
    chk("s6_flush_count", 32'(out_count), 32'd0);
    chk("s6_flush_valid", 32'(out_alu_valid), 32'd0);
    tick;
    chk("s6_after_count", 32'(out_count), 32'd0);
    chk("s6_after_valid", 32'(out_alu_valid), 32'd0);
    ins(12, 0, 0, 32'hC0, 32'h0, 32'hC00); tick;
    chk("s6_reinsert_count", 32'(out_count), 32'd1);
    tick;
    chk("s6_reissue_tag", 32'(out_alu_rob_tag), 32'd12);
    chk("s6_reissue_v1", out_alu_value1, 32'hC0);
    tick;

    // rdy low freezes a ready entry; insert under rdy low is ignored
    ins(13, 0, 0, 32'hD0, 32'h0, 32'hD00); tick;
    chk("s7_count_a", 32'(out_count), 32'd1);
    rdy = 1'b0;
    ins(14, 0, 0, 32'h0, 32'h0, 32'h0); tick;
    tick;
    chk("s7_frozen_count", 32'(out_count), 32'd1);
    chk("s7_frozen_valid", 32'(out_alu_valid), 32'd0);
    rdy = 1'b1;
    tick;
    chk("s7_resume_tag", 32'(out_alu_rob_tag), 32'd13);
    chk("s7_resume_count", 32'(out_count), 32'd0);
    tick;

    // Asynchronous reset mid-operation
    in_alu_ready = 1'b0;
    ins(9, 0, 0, 32'h90, 32'h0, 32'h900); tick;
    ins(10, 12, 0, 32'h0, 32'h0, 32'hA00); tick;
    chk("s8_pre_valid", 32'(out_alu_valid), 32'd1);
    chk("s8_pre_count", 32'(out_count), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("s8_async_count", 32'(out_count), 32'd0);
    chk("s8_async_valid", 32'(out_alu_valid), 32'd0);
    chk("s8_async_tag", 32'(out_alu_rob_tag), 32'd0);
    chk("s8_async_v1", out_alu_value1, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    in_alu_ready = 1'b1;
    ins(14, 0, 0, 32'hE0, 32'h0, 32'hE00); tick;
    chk("s8_first_insert", 32'(out_count), 32'd1);
    tick;
    chk("s8_issue_tag", 32'(out_alu_rob_tag), 32'd14);
    chk("s8_issue_v1", out_alu_value1, 32'hE0);
    chk("s8_issue_count", 32'(out_count), 32'd0);
    tick;
    chk("s8_drain_valid", 32'(out_alu_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
